huff_merge_ctrl: RTL and testbench

//  Sequencer for Huffman tree construction. Loads leaf nodes {weight[12:5],id[4:0]} into a node table.

---
 rtl/huff_pkg.sv | 38 +++
 rtl/huff_merge_ctrl_if.sv | 34 +++
 rtl/huff_min2_scan.sv | 89 ++++++++
 rtl/huff_merge_ctrl.sv | 179 +++++++++++++++++
 tb/tb_huff_merge_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/huff_pkg.sv
// Shared types and helpers for the Huffman merge sequencer.
// Node layout: {weight[W_W-1:0], id[ID_W-1:0]}.
package huff_pkg;

  localparam int N_LEAF = 16;
  localparam int W_W    = 8;
  localparam int ID_W   = 5;
  localparam int NODE_W = W_W + ID_W;
  localparam int SLOT_W = $clog2(N_LEAF);
  localparam int CNT_W  = $clog2(N_LEAF + 1);

  typedef logic [NODE_W-1:0] node_t;
  typedef logic [W_W-1:0]    weight_t;
  typedef logic [ID_W-1:0]   id_t;
  typedef logic [SLOT_W-1:0] slot_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SCAN  = 3'd2,
    ST_EMIT  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  function automatic weight_t node_weight(input node_t n);
    return n[NODE_W-1:ID_W];
  endfunction

  function automatic id_t node_id(input node_t n);
    return n[ID_W-1:0];
  endfunction

  function automatic node_t make_node(input weight_t w, input id_t id);
    return {w, id};
  endfunction

endpackage

// File: rtl/huff_merge_ctrl_if.sv
// Handshake bundle between the merge sequencer and its neighbours:
// leaf stream in from the frequency counter, merge records out to the
// code-table builder, plus start/status.
// master: the sequencer side. slave: the environment side.
interface huff_merge_ctrl_if;
  import huff_pkg::*;

  logic  start;
  logic  leaf_valid;
  logic  leaf_ready;
  node_t leaf_node;
  logic  leaf_last;
  logic  mrg_valid;
  logic  mrg_ready;
  node_t mrg_left;
  node_t mrg_right;
  node_t mrg_parent;
  logic  busy;
  logic  done;
  logic  ovf_err;

  modport master (
    input  start, leaf_valid, leaf_node, leaf_last, mrg_ready,
    output leaf_ready, mrg_valid, mrg_left, mrg_right, mrg_parent,
           busy, done, ovf_err
  );

  modport slave (
    output start, leaf_valid, leaf_node, leaf_last, mrg_ready,
    input  leaf_ready, mrg_valid, mrg_left, mrg_right, mrg_parent,
           busy, done, ovf_err
  );

endinterface

// File: rtl/huff_min2_scan.sv
// Sequential two-minimum tracker. Fed one table slot per step in ascending
// slot order; keeps the lightest (min1) and second lightest (min2) nodes.
// A strict < compare means an equal-weight entry arriving later (higher
// slot) never displaces an earlier one, so ties rank by lower slot.
// clr together with step discards the old minima and considers the
// current entry as the first of a new pass.
module huff_min2_scan
  import huff_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  clr,
  input  logic  step,
  input  logic  ent_vld,
  input  node_t ent_node,
  input  slot_t ent_slot,
  output node_t min1_node,
  output slot_t min1_slot,
  output node_t min2_node,
  output slot_t min2_slot
);

  logic  m1_vld, m2_vld;
  node_t m1_node, m2_node;
  slot_t m1_slot, m2_slot;

  logic  b1_vld, b2_vld;
  node_t b1_node, b2_node;
  slot_t b1_slot, b2_slot;

  logic  n1_vld, n2_vld;
  node_t n1_node, n2_node;
  slot_t n1_slot, n2_slot;

  // Next minima: start from current (or empty on clr) and insert the entry.
  always_comb begin
    b1_vld  = clr ? 1'b0 : m1_vld;
    b1_node = clr ? '0   : m1_node;
    b1_slot = clr ? '0   : m1_slot;
    b2_vld  = clr ? 1'b0 : m2_vld;
    b2_node = clr ? '0   : m2_node;
    b2_slot = clr ? '0   : m2_slot;
    n1_vld  = b1_vld;
    n1_node = b1_node;
    n1_slot = b1_slot;
    n2_vld  = b2_vld;
    n2_node = b2_node;
    n2_slot = b2_slot;
    if (step && ent_vld) begin
      if (!b1_vld || (node_weight(ent_node) < node_weight(b1_node))) begin
        n2_vld  = b1_vld;
        n2_node = b1_node;
        n2_slot = b1_slot;
        n1_vld  = 1'b1;
        n1_node = ent_node;
        n1_slot = ent_slot;
      end else if (!b2_vld || (node_weight(ent_node) < node_weight(b2_node))) begin
        n2_vld  = 1'b1;
        n2_node = ent_node;
        n2_slot = ent_slot;
      end
    end
  end

  // Minima registers; frozen whenever the sequencer is not scanning.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m1_vld  <= 1'b0;
      m1_node <= '0;
      m1_slot <= '0;
      m2_vld  <= 1'b0;
      m2_node <= '0;
      m2_slot <= '0;
    end else if (clr || step) begin
      m1_vld  <= n1_vld;
      m1_node <= n1_node;
      m1_slot <= n1_slot;
      m2_vld  <= n2_vld;
      m2_node <= n2_node;
      m2_slot <= n2_slot;
    end
  end

  assign min1_node = m1_node;
  assign min1_slot = m1_slot;
  assign min2_node = m2_node;
  assign min2_slot = m2_slot;

endmodule

// File: rtl/huff_merge_ctrl.sv
// Huffman tree merge sequencer. Loads leaves into a node table, then
// repeatedly picks the two lightest live nodes, emits them as a merge
// record and writes the parent back, until a single node remains.
// Optional build macro: HUFF_WSAT_EN -- parent weight saturates on
// overflow instead of wrapping. ovf_err is raised in either build.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start
// ST_LOAD  | accepting leaves into slots 0..loaded-1
// ST_SCAN  | walking slots 0..N_LEAF-1 through the two-minimum tracker
// ST_EMIT  | merge record presented, held until mrg_ready
// ST_WRITE | parent into min1 slot, min2 slot freed
// ST_DONE  | done pulse, back to idle
module huff_merge_ctrl
  import huff_pkg::*;
(
  input logic               CLK,
  input logic               nRST,
  huff_merge_ctrl_if.master bus
);

  state_t            state;
  node_t             slot_node [N_LEAF];
  logic [N_LEAF-1:0] slot_vld;
  logic [CNT_W-1:0]  loaded;
  logic [CNT_W-1:0]  loaded_nxt;
  logic [CNT_W-1:0]  live;
  id_t               next_id;
  slot_t             scan_idx;

  logic leaf_ready_r;
  logic mrg_valid_r;
  logic busy_r;
  logic done_r;
  logic ovf_r;

  logic  leaf_acc;
  logic  scan_step;
  logic  scan_clr;
  node_t min1_node, min2_node;
  slot_t min1_slot, min2_slot;

  logic [W_W:0] sum_full;
  weight_t      par_w;
  node_t        parent_node;

  assign leaf_acc   = (state == ST_LOAD) && bus.leaf_valid && leaf_ready_r;
  assign loaded_nxt = loaded + CNT_W'(1);
  assign scan_step  = (state == ST_SCAN);
  assign scan_clr   = scan_step && (scan_idx == '0);

  huff_min2_scan u_scan (
    .CLK       (CLK),
    .nRST      (nRST),
    .clr       (scan_clr),
    .step      (scan_step),
    .ent_vld   (slot_vld[scan_idx]),
    .ent_node  (slot_node[scan_idx]),
    .ent_slot  (scan_idx),
    .min1_node (min1_node),
    .min1_slot (min1_slot),
    .min2_node (min2_node),
    .min2_slot (min2_slot)
  );

  // Parent weight from the two minima; carry out is the overflow flag.
  always_comb begin
    sum_full = {1'b0, node_weight(min1_node)} + {1'b0, node_weight(min2_node)};
`ifdef HUFF_WSAT_EN
    par_w = sum_full[W_W] ? '1 : sum_full[W_W-1:0];
`else
    par_w = sum_full[W_W-1:0];
`endif
    parent_node = make_node(par_w, next_id);
  end

  // Node table payload; validity lives with the FSM so reset clears it.
  always_ff @(posedge CLK) begin
    if (leaf_acc) begin
      slot_node[loaded[SLOT_W-1:0]] <= bus.leaf_node;
    end else if (state == ST_WRITE) begin
      slot_node[min1_slot] <= parent_node;
    end
  end

  // Sequencer FSM with registered handshake and status outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= ST_IDLE;
      slot_vld     <= '0;
      loaded       <= '0;
      live         <= '0;
      next_id      <= '0;
      scan_idx     <= '0;
      leaf_ready_r <= 1'b0;
      mrg_valid_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      ovf_r        <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            state        <= ST_LOAD;
            slot_vld     <= '0;
            loaded       <= '0;
            busy_r       <= 1'b1;
            ovf_r        <= 1'b0;
            leaf_ready_r <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (leaf_acc) begin
            slot_vld[loaded[SLOT_W-1:0]] <= 1'b1;
            loaded                       <= loaded_nxt;
            if (bus.leaf_last || (loaded == CNT_W'(N_LEAF - 1))) begin
              leaf_ready_r <= 1'b0;
              live         <= loaded_nxt;
              next_id      <= id_t'(loaded_nxt);
              if (loaded == '0) begin
                state  <= ST_DONE;
                done_r <= 1'b1;
                busy_r <= 1'b0;
              end else begin
                state    <= ST_SCAN;
                scan_idx <= '0;
              end
            end
          end
        end
        ST_SCAN: begin
          scan_idx <= scan_idx + SLOT_W'(1);
          if (scan_idx == SLOT_W'(N_LEAF - 1)) begin
            state       <= ST_EMIT;
            mrg_valid_r <= 1'b1;
          end
        end
        ST_EMIT: begin
          if (bus.mrg_ready) begin
            state       <= ST_WRITE;
            mrg_valid_r <= 1'b0;
            ovf_r       <= ovf_r | sum_full[W_W];
          end
        end
        ST_WRITE: begin
          slot_vld[min2_slot] <= 1'b0;
          live                <= live - CNT_W'(1);
          next_id             <= next_id + id_t'(1);
          if (live == CNT_W'(2)) begin
            state  <= ST_DONE;
            done_r <= 1'b1;
            busy_r <= 1'b0;
          end else begin
            state    <= ST_SCAN;
            scan_idx <= '0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.leaf_ready = leaf_ready_r;
  assign bus.mrg_valid  = mrg_valid_r;
  assign bus.mrg_left   = min1_node;
  assign bus.mrg_right  = min2_node;
  assign bus.mrg_parent = parent_node;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ovf_err    = ovf_r;

endmodule

// File: tb/tb_huff_merge_ctrl.sv
// Directed bench for huff_merge_ctrl: merge order, single leaf, stall,
// overflow, mid-scan reset and a full 16-leaf load.
module tb_huff_merge_ctrl;

  logic CLK;
  logic nRST;
  int   checks;
  int   errors;

  huff_merge_ctrl_if bus ();

  huff_merge_ctrl dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [12:0] nd(input int w, input int id);
    logic [7:0] wv;
    logic [4:0] iv;
    wv = w[7:0];
    iv = id[4:0];
    return {wv, iv};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_busy", 32'(bus.busy), 1);
    chk("start_rdy", 32'(bus.leaf_ready), 1);
    chk("start_ovf_clr", 32'(bus.ovf_err), 0);
  endtask

  task automatic send_leaf(input int w, input int id, input bit last);
    bus.leaf_valid = 1'b1;
    bus.leaf_node  = nd(w, id);
    bus.leaf_last  = last;
    tick();
    bus.leaf_valid = 1'b0;
    bus.leaf_last  = 1'b0;
  endtask

  task automatic wait_valid(output int gap);
    gap = 0;
    do begin
      tick();
      gap++;
    end while (!bus.mrg_valid && gap < 200);
    chk("rec_seen", 32'(bus.mrg_valid), 1);
  endtask

  task automatic chk_rec(input string tag, input logic [12:0] l, input logic [12:0] r,
                         input logic [12:0] p);
    chk({tag, "_left"}, 32'(bus.mrg_left), 32'(l));
    chk({tag, "_right"}, 32'(bus.mrg_right), 32'(r));
    chk({tag, "_parent"}, 32'(bus.mrg_parent), 32'(p));
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.done && n < 200);
    chk("done_seen", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_mrg_valid", 32'(bus.mrg_valid), 0);
    tick();
    chk("done_pulse_end", 32'(bus.done), 0);
  endtask

  initial begin
    int gap;
    int seen;
    logic [12:0] exp_ovf_parent;
    checks = 0;
    errors = 0;
    nRST           = 1'b0;
    bus.start      = 1'b0;
    bus.leaf_valid = 1'b0;
    bus.leaf_node  = '0;
    bus.leaf_last  = 1'b0;
    bus.mrg_ready  = 1'b1;
`ifdef HUFF_WSAT_EN
    exp_ovf_parent = nd(255, 2);
`else
    exp_ovf_parent = nd(44, 2);
`endif

    // Reset state
    tick();
    tick();
    chk("rst_leaf_ready", 32'(bus.leaf_ready), 0);
    chk("rst_mrg_valid", 32'(bus.mrg_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_ovf", 32'(bus.ovf_err), 0);
    chk("rst_parent", 32'(bus.mrg_parent), 0);
    nRST = 1'b1;
    tick();

    // A: weights {5,2,9,2}
    do_start();
    send_leaf(5, 0, 1'b0);
    send_leaf(2, 1, 1'b0);
    send_leaf(9, 2, 1'b0);
    send_leaf(2, 3, 1'b1);
    chk("a_rdy_drop", 32'(bus.leaf_ready), 0);
    wait_valid(gap);
    chk_rec("a_rec1", nd(2, 1), nd(2, 3), nd(4, 4));
    wait_valid(gap);
    chk("a_gap", 32'(gap), 18);
    chk_rec("a_rec2", nd(4, 4), nd(5, 0), nd(9, 5));
    wait_valid(gap);
    chk_rec("a_rec3", nd(9, 5), nd(9, 2), nd(18, 6));
    wait_done();
    chk("a_ovf", 32'(bus.ovf_err), 0);

    // B: single leaf
    do_start();
    send_leaf(7, 0, 1'b1);
    chk("b_done", 32'(bus.done), 1);
    chk("b_busy", 32'(bus.busy), 0);
    chk("b_no_rec", 32'(bus.mrg_valid), 0);
    tick();
    chk("b_done_end", 32'(bus.done), 0);
    chk("b_no_rec2", 32'(bus.mrg_valid), 0);

    // C: stall in EMIT
    bus.mrg_ready = 1'b0;
    do_start();
    send_leaf(3, 0, 1'b0);
    send_leaf(1, 1, 1'b0);
    send_leaf(2, 2, 1'b1);
    wait_valid(gap);
    chk_rec("c_rec1", nd(1, 1), nd(2, 2), nd(3, 3));
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("c_stall_valid", 32'(bus.mrg_valid), 1);
      chk_rec("c_stall", nd(1, 1), nd(2, 2), nd(3, 3));
    end
    bus.mrg_ready = 1'b1;
    tick();
    chk("c_accept", 32'(bus.mrg_valid), 0);
    wait_valid(gap);
    chk("c_gap", 32'(gap), 17);
    chk_rec("c_rec2", nd(3, 0), nd(3, 3), nd(6, 4));
    wait_done();

    // D: weight overflow
    do_start();
    send_leaf(200, 0, 1'b0);
    send_leaf(100, 1, 1'b1);
    wait_valid(gap);
    chk_rec("d_rec", nd(100, 1), nd(200, 0), exp_ovf_parent);
    chk("d_ovf_pre", 32'(bus.ovf_err), 0);
    tick();
    chk("d_ovf_set", 32'(bus.ovf_err), 1);
    wait_done();
    chk("d_ovf_sticky", 32'(bus.ovf_err), 1);

    // E: reset mid-SCAN, then a clean run
    do_start();
    send_leaf(4, 0, 1'b0);
    send_leaf(7, 1, 1'b1);
    for (int k = 0; k < 5; k++) tick();
    chk("e_busy_pre", 32'(bus.busy), 1);
    nRST = 1'b0;
    #1;
    chk("e_rst_busy", 32'(bus.busy), 0);
    chk("e_rst_valid", 32'(bus.mrg_valid), 0);
    chk("e_rst_rdy", 32'(bus.leaf_ready), 0);
    chk("e_rst_done", 32'(bus.done), 0);
    chk("e_rst_parent", 32'(bus.mrg_parent), 0);
    tick();
    nRST = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (bus.mrg_valid || bus.busy) seen++;
    end
    chk("e_quiet", 32'(seen), 0);
    do_start();
    send_leaf(6, 0, 1'b0);
    send_leaf(1, 1, 1'b1);
    wait_valid(gap);
    chk_rec("e_rec", nd(1, 1), nd(6, 0), nd(7, 2));
    wait_done();

    // F: 16 leaves, no leaf_last
    do_start();
    for (int i = 0; i < 16; i++) begin
      chk("f_rdy", 32'(bus.leaf_ready), 1);
      bus.leaf_valid = 1'b1;
      bus.leaf_node  = nd(1, i);
      bus.leaf_last  = 1'b0;
      tick();
    end
    chk("f_rdy_drop", 32'(bus.leaf_ready), 0);
    bus.leaf_valid = 1'b0;
    for (int r = 0; r < 15; r++) begin
      wait_valid(gap);
      chk("f_parent_id", 32'(bus.mrg_parent[4:0]), 32'(16 + r));
      if (r > 0) chk("f_gap", 32'(gap), 18);
      if (r == 0) chk_rec("f_rec1", nd(1, 0), nd(1, 1), nd(2, 16));
      if (r == 14) chk("f_root_w", 32'(bus.mrg_parent[12:5]), 16);
    end
    wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
